// File: rtl/exe_muldiv_unit.sv
// exe_muldiv_unit
//   Iterative RV32M multiply/divide unit living in the EXE stage. It takes one
//   operand pair from ID_EXE and runs a shift-add multiply or a restoring
//   divide, one bit per cycle. While it works it pulls exe_ready low so the
//   hazard unit freezes everything upstream and the operands stay put.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   op_valid   ID_EXE holds an M-extension instruction
//   op_funct3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
//   rs1_data   operand A (after forwarding)
//   rs2_data   operand B (after forwarding)
//   advance    ID_EXE -> EXE_MEM moves this cycle
//   flush      kill any in-flight operation
//   exe_ready  low = stall upstream stages
//   done       result valid this cycle
//   result     product half / quotient / remainder
module exe_muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            op_valid,
  input  logic [2:0]      op_funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            advance,
  input  logic            flush,
  output logic            exe_ready,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [XLEN-1:0]  MIN_INT   = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t state;
  state_t state_next;

  // hi/lo hold {product high, product low} for multiply and
  // {remainder, quotient} for divide; opb is multiplicand or divisor.
  logic [CNT_W-1:0] count;
  logic [XLEN-1:0]  hi;
  logic [XLEN-1:0]  lo;
  logic [XLEN-1:0]  opb;
  logic [2:0]       funct3;
  logic             neg_pq;
  logic             neg_r;

  logic            accept;
  logic            signed_a;
  logic            signed_b;
  logic            sign_a;
  logic            sign_b;
  logic            is_div;
  logic            div_zero;
  logic            div_ovf;
  logic [XLEN-1:0] abs_a;
  logic [XLEN-1:0] abs_b;

  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift;
  logic [XLEN:0]   div_trial;

  logic [2*XLEN-1:0] product_c;
  logic [XLEN-1:0]   result_sel;

  assign accept = (state == IDLE) && op_valid && !flush;

  // Operand decode at accept time: which operands are treated as signed,
  // their magnitudes, and whether a divide can skip the iterative loop.
  always_comb begin
    signed_a = (op_funct3 == 3'd1) || (op_funct3 == 3'd2) ||
               (op_funct3 == 3'd4) || (op_funct3 == 3'd6);
    signed_b = (op_funct3 == 3'd1) || (op_funct3 == 3'd4) ||
               (op_funct3 == 3'd6);
    sign_a   = signed_a && rs1_data[XLEN-1];
    sign_b   = signed_b && rs2_data[XLEN-1];
    abs_a    = sign_a ? -rs1_data : rs1_data;
    abs_b    = sign_b ? -rs2_data : rs2_data;
    is_div   = op_funct3[2];
    div_zero = is_div && (rs2_data == '0);
    // Only the signed forms can overflow (MIN_INT / -1).
    div_ovf  = is_div && !op_funct3[0] && (rs1_data == MIN_INT) &&
               (rs2_data == '1);
  end

  // One iteration step for each algorithm. The extra top bit keeps the
  // multiply carry and serves as the borrow flag of the trial subtract.
  always_comb begin
    mul_sum   = lo[0] ? ({1'b0, hi} + {1'b0, opb}) : {1'b0, hi};
    div_shift = {hi, lo[XLEN-1]};
    div_trial = div_shift - {1'b0, opb};
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. Flush beats everything; DONE only leaves on advance so a
  // dcache-miss stall cannot cause the op to run again.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = (div_zero || div_ovf) ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (count == LAST_ITER) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (advance) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (flush) begin
      state_next = IDLE;
    end
  end

  // Datapath registers. Fast-path divides store final values with the
  // negate flags cleared, so the DONE selection needs no special case.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      hi     <= '0;
      lo     <= '0;
      opb    <= '0;
      funct3 <= '0;
      neg_pq <= 1'b0;
      neg_r  <= 1'b0;
    end else if (accept) begin
      funct3 <= op_funct3;
      count  <= '0;
      if (div_zero) begin
        lo     <= '1;
        hi     <= rs1_data;
        opb    <= '0;
        neg_pq <= 1'b0;
        neg_r  <= 1'b0;
      end else if (div_ovf) begin
        lo     <= MIN_INT;
        hi     <= '0;
        opb    <= '0;
        neg_pq <= 1'b0;
        neg_r  <= 1'b0;
      end else begin
        lo     <= abs_a;
        hi     <= '0;
        opb    <= abs_b;
        neg_pq <= sign_a ^ sign_b;
        neg_r  <= sign_a;
      end
    end else if ((state == BUSY) && !flush) begin
      count <= count + CNT_W'(1);
      if (funct3[2]) begin
        if (!div_trial[XLEN]) begin
          hi <= div_trial[XLEN-1:0];
          lo <= {lo[XLEN-2:0], 1'b1};
        end else begin
          hi <= div_shift[XLEN-1:0];
          lo <= {lo[XLEN-2:0], 1'b0};
        end
      end else begin
        hi <= mul_sum[XLEN:1];
        lo <= {mul_sum[0], lo[XLEN-1:1]};
      end
    end
  end

  // Output logic. The product is sign-corrected as a full 2*XLEN value so
  // both MUL and MULH* read from the same corrected word.
  always_comb begin
    product_c = neg_pq ? -{hi, lo} : {hi, lo};
    case (funct3)
      3'd0:          result_sel = product_c[XLEN-1:0];
      3'd1, 3'd2,
      3'd3:          result_sel = product_c[2*XLEN-1:XLEN];
      3'd4, 3'd5:    result_sel = neg_pq ? -lo : lo;
      default:       result_sel = neg_r ? -hi : hi;
    endcase
    done      = (state == DONE) && !flush;
    result    = done ? result_sel : '0;
    exe_ready = !(accept || (state == BUSY));
  end

endmodule

// File: tb/tb_exe_muldiv_unit.sv
// tb_exe_muldiv_unit
//   Directed bench for exe_muldiv_unit: a table of operations with
//   hand-computed results and stall counts, plus hand-written sequences for
//   the DONE hold, flush mid-operation and reset mid-operation cases.
module tb_exe_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        op_valid = 1'b0;
  logic [2:0]  op_funct3 = 3'd0;
  logic [31:0] rs1_data = 32'd0;
  logic [31:0] rs2_data = 32'd0;
  logic        advance = 1'b0;
  logic        flush = 1'b0;
  logic        exe_ready;
  logic        done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic [7:0]  stall;
  } vec_t;

  localparam int NVEC = 16;
  vec_t vecs [NVEC];

  always #5 clk = ~clk;

  exe_muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .op_valid  (op_valid),
    .op_funct3 (op_funct3),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .advance   (advance),
    .flush     (flush),
    .exe_ready (exe_ready),
    .done      (done),
    .result    (result)
  );

  // Hard stop in case the design wedges somewhere no bounded loop covers.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got hang, expected finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic applyStimulus(input logic v, input logic [2:0] f,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic adv, input logic fl);
    op_valid  = v;
    op_funct3 = f;
    rs1_data  = a;
    rs2_data  = b;
    advance   = adv;
    flush     = fl;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Issue one op with advance held high, count stall cycles until
  // exe_ready rises, check the result, then confirm the unit went idle.
  task automatic runOp(input string name, input logic [2:0] f,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int exp_stall);
    int stall;
    logic ok;
    stall = 0;
    ok = 1'b0;
    @(posedge clk); #1;
    applyStimulus(1'b1, f, a, b, 1'b1, 1'b0);
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (exe_ready) begin
        ok = 1'b1;
        break;
      end
      stall++;
    end
    checkOutput({name, " reached_done"}, {31'd0, ok}, 32'd1);
    checkOutput({name, " stall_cycles"}, stall, exp_stall);
    checkOutput({name, " done"}, {31'd0, done}, 32'd1);
    checkOutput({name, " result"}, result, exp);
    @(posedge clk); #1;
    applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput({name, " idle_done"}, {31'd0, done}, 32'd0);
    checkOutput({name, " idle_ready"}, {31'd0, exe_ready}, 32'd1);
  endtask

  initial begin
    logic seen_done;
    logic ok;

    vecs[0]  = '{3'd0, 32'h00000007, 32'hFFFFFFF9, 32'hFFFFFFCF, 8'd33};
    vecs[1]  = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 8'd33};
    vecs[2]  = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 8'd33};
    vecs[3]  = '{3'd2, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 8'd33};
    vecs[4]  = '{3'd4, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 8'd33};
    vecs[5]  = '{3'd6, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 8'd33};
    vecs[6]  = '{3'd5, 32'd100,      32'd7,        32'd14,       8'd33};
    vecs[7]  = '{3'd7, 32'd100,      32'd7,        32'd2,        8'd33};
    vecs[8]  = '{3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 8'd1};
    vecs[9]  = '{3'd6, 32'd5,        32'd0,        32'd5,        8'd1};
    vecs[10] = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 8'd1};
    vecs[11] = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0,        8'd1};
    vecs[12] = '{3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 8'd33};
    vecs[13] = '{3'd1, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 8'd33};
    vecs[14] = '{3'd4, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, 8'd1};
    vecs[15] = '{3'd7, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 8'd33};

    // Reset values while rst_n is held low.
    #12;
    checkOutput("reset done", {31'd0, done}, 32'd0);
    checkOutput("reset result", result, 32'd0);
    checkOutput("reset ready", {31'd0, exe_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Non-M traffic: unit stays idle and transparent.
    repeat (3) @(negedge clk);
    checkOutput("nonM ready", {31'd0, exe_ready}, 32'd1);
    checkOutput("nonM done", {31'd0, done}, 32'd0);

    for (int i = 0; i < NVEC; i++) begin
      runOp($sformatf("vec%0d", i), vecs[i].f, vecs[i].a, vecs[i].b,
            vecs[i].exp, int'(vecs[i].stall));
    end

    // DIV 100/7 completing with advance low: result must hold for 4 cycles
    // with op_valid still high, then leave once advance arrives.
    @(posedge clk); #1;
    applyStimulus(1'b1, 3'd4, 32'd100, 32'd7, 1'b0, 1'b0);
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (exe_ready) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput("hold reached_done", {31'd0, ok}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      checkOutput($sformatf("hold%0d done", k), {31'd0, done}, 32'd1);
      checkOutput($sformatf("hold%0d result", k), result, 32'd14);
      checkOutput($sformatf("hold%0d ready", k), {31'd0, exe_ready}, 32'd1);
    end
    @(posedge clk); #1;
    applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("hold last done", {31'd0, done}, 32'd1);
    @(posedge clk); #1;
    applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("hold exit done", {31'd0, done}, 32'd0);
    checkOutput("hold exit ready", {31'd0, exe_ready}, 32'd1);

    // Flush a MUL while BUSY with counter at 10; done must never pulse.
    @(posedge clk); #1;
    applyStimulus(1'b1, 3'd0, 32'd5, 32'd6, 1'b0, 1'b0);
    seen_done = 1'b0;
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
      @(posedge clk);
    end
    #1;
    applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("flush busy ready", {31'd0, exe_ready}, 32'd0);
    if (done) seen_done = 1'b1;
    @(posedge clk); #1;
    applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("flush idle ready", {31'd0, exe_ready}, 32'd1);
    for (int k = 0; k < 40; k++) begin
      if (done) seen_done = 1'b1;
      @(negedge clk);
    end
    checkOutput("flush no done", {31'd0, seen_done}, 32'd0);

    // Reset in the middle of a MUL at counter 20.
    @(posedge clk); #1;
    applyStimulus(1'b1, 3'd0, 32'd9, 32'd9, 1'b1, 1'b0);
    repeat (21) @(posedge clk);
    #1;
    rst_n = 1'b0;
    applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    #1;
    checkOutput("midreset done", {31'd0, done}, 32'd0);
    checkOutput("midreset result", result, 32'd0);
    checkOutput("midreset ready", {31'd0, exe_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("postreset done", {31'd0, done}, 32'd0);

    runOp("mul3x4", 3'd0, 32'd3, 32'd4, 32'd12, 33);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
